// File: rtl/soc_mem_responder.sv
// Memory-bus slave: word RAM with byte-masked writes, LED register and an 8N1 UART transmitter.
// RAM has no initial contents; MEM_INIT_FILE is kept for interface compatibility only.
//
// UART state | meaning
// S_IDLE     | line idle high, ready to accept a byte
// S_START    | driving start bit (0)
// S_DATA     | shifting data bits out LSB first, bit_cnt 0..7
// S_STOP     | driving stop bit (1); a byte written now is dropped
module soc_mem_responder #(
  parameter int MEM_WORDS     = 1536,
  parameter int IO_BIT        = 22,
  parameter int BAUD_DIV      = 104,
  parameter     MEM_INIT_FILE = "firmware.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        mem_rstrb,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [4:0]  leds,
  output logic        uart_txd
);

  localparam int IDX_W  = IO_BIT - 2;
  localparam int RAM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam logic [IDX_W:0]    MEM_WORDS_V = (IDX_W + 1)'(MEM_WORDS);
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic [31:0]       ram [0:MEM_WORDS-1];
  logic              io_sel;
  logic [IDX_W-1:0]  word_idx;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_hit;
  logic [1:0]        io_reg;
  logic              wr_en;
  logic              led_wr;
  logic              tx_wr;
  logic              tx_accept;
  logic              tx_drop;
  logic              stat_rd;
  logic              busy;
  logic              overrun;
  logic [31:0]       rd_value;
  logic              unused_addr_bits;

  uart_state_t       state, state_nx;
  logic [BAUD_W-1:0] baud_cnt, baud_nx;
  logic [2:0]        bit_cnt, bit_nx;
  logic [7:0]        shifter, shift_nx;
  logic              txd_nx;
  logic              baud_done;

  assign io_sel   = mem_addr[IO_BIT];
  assign word_idx = mem_addr[IO_BIT-1:2];
  assign ram_idx  = word_idx[RAM_AW-1:0];
  assign ram_hit  = !io_sel && ({1'b0, word_idx} < MEM_WORDS_V);
  assign io_reg   = mem_addr[3:2];
  assign wr_en    = |mem_wmask;

  assign led_wr    = io_sel && (io_reg == 2'd0) && mem_wmask[0];
  assign tx_wr     = io_sel && (io_reg == 2'd1) && mem_wmask[0];
  assign stat_rd   = io_sel && (io_reg == 2'd2) && mem_rstrb;
  assign busy      = (state != S_IDLE);
  assign tx_accept = tx_wr && !busy;
  assign tx_drop   = tx_wr && busy;

  assign unused_addr_bits = ^{mem_addr[31:IO_BIT+1], mem_addr[1:0]};

  // RAM carries no reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (ram_hit && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wmask[i]) ram[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_value = '0;
    if (io_sel) begin
      unique case (io_reg)
        2'd0:    rd_value = {27'b0, leds};
        2'd2:    rd_value = {30'b0, overrun, busy};
        default: rd_value = '0;
      endcase
    end else if (ram_hit) begin
      rd_value = ram[ram_idx];
    end
  end

  // Status sampled before this edge's updates, so a read sees the pre-clear overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= '0;
      leds      <= '0;
      overrun   <= 1'b0;
    end else begin
      if (mem_rstrb) mem_rdata <= rd_value;
      if (led_wr)    leds      <= mem_wdata[4:0];
      if (tx_drop)      overrun <= 1'b1;
      else if (stat_rd) overrun <= 1'b0;
    end
  end

  assign baud_done = (baud_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shifter  <= shift_nx;
      uart_txd <= txd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shifter;
    txd_nx   = uart_txd;
    if (state != S_IDLE) baud_nx = baud_done ? BAUD_LAST : baud_cnt - 1'b1;
    unique case (state)
      S_IDLE: begin
        txd_nx = 1'b1;
        if (tx_accept) begin
          state_nx = S_START;
          baud_nx  = BAUD_LAST;
          bit_nx   = 3'd0;
          shift_nx = mem_wdata[7:0];
          txd_nx   = 1'b0;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_nx = S_DATA;
          bit_nx   = 3'd0;
          txd_nx   = shifter[0];
        end
      end
      S_DATA: begin
        if (baud_done) begin
          if (bit_cnt == 3'd7) begin
            state_nx = S_STOP;
            txd_nx   = 1'b1;
          end else begin
            bit_nx   = bit_cnt + 1'b1;
            shift_nx = {1'b0, shifter[7:1]};
            txd_nx   = shifter[1];
          end
        end
      end
      S_STOP: begin
        if (baud_done) begin
          state_nx = S_IDLE;
          txd_nx   = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_soc_mem_responder.sv
// Bench for soc_mem_responder: vector table, randomized RAM/LED traffic against a
// word-array model, and hand sequences for UART framing, overrun and async reset.
module tb_soc_mem_responder;

  localparam int MEM_WORDS = 1536;
  localparam int IO_BIT    = 22;
  localparam int BAUD_DIV  = 4;
  localparam logic [31:0] IO_BASE = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [4:0]  leds;
  logic        uart_txd;

  int n_vec = 0;
  int n_bad = 0;

  soc_mem_responder #(
    .MEM_WORDS(MEM_WORDS), .IO_BIT(IO_BIT), .BAUD_DIV(BAUD_DIV), .MEM_INIT_FILE("firmware.hex")
  ) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .leds(leds), .uart_txd(uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_leds;
  } vec_t;

  vec_t tbl[$];

  logic [31:0] ref_ram [int];
  logic [4:0]  ref_leds;
  logic [31:0] ref_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic r);
    mem_addr  = a;
    mem_wdata = d;
    mem_wmask = m;
    mem_rstrb = r;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 4'b0000, 1'b0);
  endtask

  // Called at a negedge: one access sampled by the following posedge, back to idle at the next negedge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic r);
    drive(a, d, m, r);
    @(negedge clk);
    idle();
  endtask

  task automatic add_vec(input string n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         input logic r, input logic [31:0] er, input logic [4:0] el);
    vec_t v;
    v.name = n; v.addr = a; v.wdata = d; v.wmask = m; v.rstrb = r;
    v.exp_rdata = er; v.exp_leds = el;
    tbl.push_back(v);
  endtask

  // Send one byte and follow the whole frame; inject_k places a second UART write at that cycle.
  task automatic uart_frame(input logic [7:0] b, input int inject_k, input string tag);
    int exp_bit;
    cycle(IO_BASE + 32'h4, {24'h0, b}, 4'b0001, 1'b0);
    for (int k = 0; k < 10 * BAUD_DIV; k++) begin
      if (k < BAUD_DIV) exp_bit = 0;
      else if (k >= 9 * BAUD_DIV) exp_bit = 1;
      else exp_bit = (int'(b) >> ((k - BAUD_DIV) / BAUD_DIV)) & 1;
      check($sformatf("%s_txd_c%0d", tag, k), {31'b0, uart_txd}, 32'(exp_bit));
      if (k == 10 * BAUD_DIV - 1)
        check({tag, "_status_in_stop"}, mem_rdata, {30'b0, (inject_k == 1), 1'b1});
      idle();
      if (k == inject_k) drive(IO_BASE + 32'h4, 32'h42, 4'b0001, 1'b0);
      if (k == 10 * BAUD_DIV - 2) drive(IO_BASE + 32'h8, 32'h0, 4'b0000, 1'b1);
      @(negedge clk);
    end
    check({tag, "_txd_idle_after"}, {31'b0, uart_txd}, 32'h1);
    cycle(IO_BASE + 32'h8, 32'h0, 4'b0000, 1'b1);
    check({tag, "_status_after"}, mem_rdata, (inject_k == 10 * BAUD_DIV - 1) ? 32'h2 : 32'h0);
    cycle(IO_BASE + 32'h8, 32'h0, 4'b0000, 1'b1);
    check({tag, "_status_cleared"}, mem_rdata, 32'h0);
    check({tag, "_txd_still_idle"}, {31'b0, uart_txd}, 32'h1);
  endtask

  initial begin
    int kind, idx;
    logic [31:0] a, d, old;
    logic [3:0]  m;
    logic        r;

    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_leds", {27'b0, leds}, 32'h0);
    check("reset_txd", {31'b0, uart_txd}, 32'h1);
    reset = 1'b0;
    @(negedge clk);

    add_vec("wr_full",       32'h10,           32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,        5'h00);
    add_vec("wr_byte1",      32'h10,           32'h0000AA00, 4'b0010, 1'b0, 32'h0,        5'h00);
    add_vec("rd_merge",      32'h10,           32'h0,        4'b0000, 1'b1, 32'hDEADAAEF, 5'h00);
    add_vec("hold1",         32'h0,            32'h0,        4'b0000, 1'b0, 32'hDEADAAEF, 5'h00);
    add_vec("hold2",         32'h0,            32'h0,        4'b0000, 1'b0, 32'hDEADAAEF, 5'h00);
    add_vec("hold3",         32'h0,            32'h0,        4'b0000, 1'b0, 32'hDEADAAEF, 5'h00);
    add_vec("wr_w0",         32'h0,            32'hCAFEF00D, 4'b1111, 1'b0, 32'hDEADAAEF, 5'h00);
    add_vec("rd_oor",        32'h1800,         32'h0,        4'b0000, 1'b1, 32'h0,        5'h00);
    add_vec("wr_oor",        32'h1800,         32'h12345678, 4'b1111, 1'b0, 32'h0,        5'h00);
    add_vec("rd_w0",         32'h0,            32'h0,        4'b0000, 1'b1, 32'hCAFEF00D, 5'h00);
    add_vec("wr_leds",       IO_BASE,          32'h1F,       4'b0001, 1'b0, 32'hCAFEF00D, 5'h1F);
    add_vec("rd_leds",       IO_BASE,          32'h0,        4'b0000, 1'b1, 32'h1F,       5'h1F);
    add_vec("wr_leds_nolo",  IO_BASE,          32'h0,        4'b1110, 1'b0, 32'h1F,       5'h1F);
    add_vec("rd_io3",        IO_BASE + 32'hC,  32'h0,        4'b0000, 1'b1, 32'h0,        5'h1F);
    add_vec("rw_io3",        IO_BASE + 32'hC,  32'hFFFFFFFF, 4'b1111, 1'b1, 32'h0,        5'h1F);
    add_vec("rd_status",     IO_BASE + 32'h8,  32'h0,        4'b0000, 1'b1, 32'h0,        5'h1F);
    add_vec("rd_leds2",      IO_BASE,          32'h0,        4'b0000, 1'b1, 32'h1F,       5'h1F);
    add_vec("rd_uartdata",   IO_BASE + 32'h4,  32'h0,        4'b0000, 1'b1, 32'h0,        5'h1F);
    add_vec("rd_leds_alias", IO_BASE + 32'h10, 32'h0,        4'b0000, 1'b1, 32'h1F,       5'h1F);
    add_vec("wr_last",       32'h17FC,         32'hA5A5A5A5, 4'b1111, 1'b0, 32'h1F,       5'h1F);
    add_vec("rd_last",       32'h17FC,         32'h0,        4'b0000, 1'b1, 32'hA5A5A5A5, 5'h1F);
    add_vec("wr_20",         32'h20,           32'h11111111, 4'b1111, 1'b0, 32'hA5A5A5A5, 5'h1F);
    add_vec("rw_same",       32'h20,           32'h22222222, 4'b1111, 1'b1, 32'h11111111, 5'h1F);
    add_vec("rd_20",         32'h20,           32'h0,        4'b0000, 1'b1, 32'h22222222, 5'h1F);
    add_vec("rd_w0_noalias", 32'h0,            32'h0,        4'b0000, 1'b1, 32'hCAFEF00D, 5'h1F);

    foreach (tbl[i]) begin
      cycle(tbl[i].addr, tbl[i].wdata, tbl[i].wmask, tbl[i].rstrb);
      check({tbl[i].name, "_rdata"}, mem_rdata, tbl[i].exp_rdata);
      check({tbl[i].name, "_leds"}, {27'b0, leds}, {27'b0, tbl[i].exp_leds});
    end

    ref_leds  = 5'h1F;
    ref_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      ref_ram[64 + i] = d;
      cycle(32'((64 + i) * 4), d, 4'b1111, 1'b0);
    end
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 7);
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      r = 1'($urandom_range(0, 1));
      if (kind < 6) begin
        idx = 64 + $urandom_range(0, 15);
        a = 32'(idx * 4 + $urandom_range(0, 3));
        old = ref_ram[idx];
        if (r) ref_rdata = old;
        for (int l = 0; l < 4; l++)
          if (m[l]) old[8*l +: 8] = d[8*l +: 8];
        ref_ram[idx] = old;
      end else if (kind == 6) begin
        a = IO_BASE + 32'($urandom_range(0, 3));
        if (r) ref_rdata = {27'b0, ref_leds};
        if (m[0]) ref_leds = d[4:0];
      end else begin
        a = 32'((MEM_WORDS + $urandom_range(0, 1000)) * 4);
        if (r) ref_rdata = 32'h0;
      end
      cycle(a, d, m, r);
      check($sformatf("rand%0d_rdata", n), mem_rdata, ref_rdata);
      check($sformatf("rand%0d_leds", n), {27'b0, leds}, {27'b0, ref_leds});
    end
    for (int i = 0; i < 16; i++) begin
      cycle(32'((64 + i) * 4), 32'h0, 4'b0000, 1'b1);
      check($sformatf("rand_final_w%0d", i), mem_rdata, ref_ram[64 + i]);
    end

    uart_frame(8'h55, -1, "frame55");
    uart_frame(8'h41, 1, "overrun41");
    uart_frame(8'hC3, 10 * BAUD_DIV - 1, "stopedge");

    cycle(IO_BASE, 32'h15, 4'b0001, 1'b0);
    cycle(32'h10, 32'h0, 4'b0000, 1'b1);
    check("pre_rst_rdata", mem_rdata, 32'hDEADAAEF);
    check("pre_rst_leds", {27'b0, leds}, 32'h15);
    cycle(IO_BASE + 32'h4, 32'hA5, 4'b0001, 1'b0);
    repeat (2 * BAUD_DIV + 1) @(negedge clk);
    check("pre_rst_txd", {31'b0, uart_txd}, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_txd", {31'b0, uart_txd}, 32'h1);
    check("async_rst_leds", {27'b0, leds}, 32'h0);
    check("async_rst_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle(IO_BASE + 32'h8, 32'h0, 4'b0000, 1'b1);
    check("post_rst_status", mem_rdata, 32'h0);
    uart_frame(8'h0F, -1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
